axi_rd_mem_stub: RTL

- Parametrised AXI4 read-only memory model used as the DRAM-side stub behind prefetcherTop in block and system benches.
- It improves on the single-request, fixed-timing RAM stub in three ways:
  - accepts multiple outstanding AR requests into a FIFO;
  - returns each burst after a programmable fixed latency, in order;
  - supports R-channel backpressure, injected stalls and per-beat decode errors.
- Memory contents are loaded through a backdoor write port, so benches need no AW/W traffic.

---
 rtl/axi_rd_mem_stub.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/axi_rd_mem_stub.sv
// AXI4 read-only memory stub: queues AR requests, returns bursts in order after a
// fixed latency, with R backpressure, stall injection and DECERR beyond backed memory.
module axi_rd_mem_stub #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned ID_WIDTH      = 8,
   parameter int unsigned LEN_WIDTH     = 8,
   parameter int unsigned LOG_DEPTH     = 2,
   parameter int unsigned LATENCY       = 4,
   parameter int unsigned MEM_WORDS_LOG = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ID_WIDTH-1:0]      s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
   input  logic [LEN_WIDTH-1:0]     s_axi_arlen,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   output logic [ID_WIDTH-1:0]      s_axi_rid,
   output logic [DATA_WIDTH-1:0]    s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rlast,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   input  logic                     bd_wr_en,
   input  logic [MEM_WORDS_LOG-1:0] bd_wr_addr,
   input  logic [DATA_WIDTH-1:0]    bd_wr_data,
   input  logic                     stall_inject,
   output logic [LOG_DEPTH:0]       outstanding_cnt
);
   localparam int unsigned DEPTH     = 2 ** LOG_DEPTH;
   localparam int unsigned BYTE_BITS = $clog2(DATA_WIDTH / 8);
   localparam int unsigned WORD_W    = ADDR_WIDTH - BYTE_BITS;
   localparam int unsigned MEM_WORDS = 2 ** MEM_WORDS_LOG;
   localparam int unsigned CNT_W     = $clog2(LATENCY + 1);

   typedef enum logic {R_IDLE, R_BEAT} r_state_t;

   logic [DATA_WIDTH-1:0] mem    [MEM_WORDS];
   logic [ID_WIDTH-1:0]   q_id   [DEPTH];
   logic [WORD_W-1:0]     q_word [DEPTH];
   logic [LEN_WIDTH-1:0]  q_len  [DEPTH];
   logic [CNT_W-1:0]      q_cnt  [DEPTH];

   logic [LOG_DEPTH-1:0]     wr_ptr, rd_ptr, cand_sel;
   logic [LOG_DEPTH:0]       count;
   logic                     push, pop, r_fire, load;
   logic                     cand_avail, cand_elig, in_range;
   logic [LEN_WIDTH-1:0]     cand_beat, next_beat;
   logic [WORD_W-1:0]        cand_word;
   logic [MEM_WORDS_LOG-1:0] mem_idx;
   r_state_t                 state, state_nxt;

   assign s_axi_arready   = (count != (LOG_DEPTH+1)'(DEPTH)) && !rst;
   assign push            = s_axi_arvalid && s_axi_arready;
   assign r_fire          = s_axi_rvalid && s_axi_rready;
   assign pop             = r_fire && s_axi_rlast;
   assign outstanding_cnt = count;

   // On the last-beat handshake the candidate is the entry behind the head, so the
   // next burst can start in the very next cycle. Eligibility looks at cnt<=1 because
   // the counter reaches zero at the same edge that registers the beat.
   always_comb begin
      cand_sel   = pop ? rd_ptr + LOG_DEPTH'(1) : rd_ptr;
      cand_avail = pop ? (count > (LOG_DEPTH+1)'(1)) : (count != '0);
      cand_beat  = pop ? '0 : next_beat;
      cand_elig  = (q_cnt[cand_sel] <= CNT_W'(1));
      cand_word  = q_word[cand_sel] + WORD_W'(cand_beat);
      mem_idx    = MEM_WORDS_LOG'(cand_word);
      in_range   = (WORD_W'(mem_idx) == cand_word);
      load       = (!s_axi_rvalid || r_fire) && cand_avail && cand_elig && !stall_inject;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= R_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         R_IDLE:  if (load) state_nxt = R_BEAT;
         R_BEAT:  if (r_fire && !load) state_nxt = R_IDLE;
         default: state_nxt = R_IDLE;
      endcase
   end

   always_comb s_axi_rvalid = (state == R_BEAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_rid   <= '0;
         s_axi_rdata <= '0;
         s_axi_rresp <= '0;
         s_axi_rlast <= 1'b0;
         next_beat   <= '0;
      end else if (load) begin
         s_axi_rid   <= q_id[cand_sel];
         s_axi_rdata <= in_range ? mem[mem_idx] : '0;
         s_axi_rresp <= in_range ? 2'b00 : 2'b11;
         s_axi_rlast <= (cand_beat == q_len[cand_sel]);
         next_beat   <= cand_beat + LEN_WIDTH'(1);
      end else if (pop) begin
         s_axi_rlast <= 1'b0;
         next_beat   <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) q_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++)
            if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - CNT_W'(1);
         if (push) begin
            q_cnt[wr_ptr] <= CNT_W'(LATENCY);
            wr_ptr        <= wr_ptr + LOG_DEPTH'(1);
         end
         if (pop) rd_ptr <= rd_ptr + LOG_DEPTH'(1);
         case ({push, pop})
            2'b10:   count <= count + (LOG_DEPTH+1)'(1);
            2'b01:   count <= count - (LOG_DEPTH+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_id[wr_ptr]   <= s_axi_arid;
         q_word[wr_ptr] <= s_axi_araddr[ADDR_WIDTH-1:BYTE_BITS];
         q_len[wr_ptr]  <= s_axi_arlen;
      end
   end

   // Backing store is deliberately outside reset so loaded contents survive rst.
   always_ff @(posedge clk) begin
      if (bd_wr_en) mem[bd_wr_addr] <= bd_wr_data;
   end

endmodule
